program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 23 ++
 rtl/program_loader_word_assembler.sv | 31 +++
 rtl/program_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Fallback memory geometry, used only when the build supplies none.
`ifndef PROGRAM_MEMORY_ADDRESS_BITWIDTH
`define PROGRAM_MEMORY_ADDRESS_BITWIDTH 10
`endif
`ifndef PROGRAM_MEMORY_SIZE_BYTE
`define PROGRAM_MEMORY_SIZE_BYTE 1024
`endif

package program_loader_pkg;

   localparam int unsigned HEADER_BYTES = 4;
   localparam int unsigned WORD_BYTES   = 4;

   typedef enum logic [2:0] {
      StHeader,
      StPayload,
      StChecksum,
      StDone,
      StError
   } state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word assembler; flags the byte that completes a word.
module word_assembler
   import program_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_done
);

   // The three earlier bytes of the current word, oldest in the low byte.
   logic [23:0] shift;
   logic [1:0]  count;

   assign word      = {byte_data, shift};
   assign word_done = byte_valid && (count == 2'(WORD_BYTES - 1));

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         shift <= 24'h0;
         count <= 2'd0;
      end else if (byte_valid) begin
         shift <= {byte_data, shift[23:8]};
         count <= count + 2'd1;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed program image from a UART byte stream
// into program memory and reports completion or failure.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = `PROGRAM_MEMORY_ADDRESS_BITWIDTH,
   parameter int unsigned MEM_WORDS = `PROGRAM_MEMORY_SIZE_BYTE / 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              restart,
   output logic [ADDR_W-1:0] mem_write_address,
   output logic [31:0]       mem_write_data,
   output logic              mem_write_enable,
   output logic              load_done,
   output logic              load_error
);

   localparam int unsigned CNT_W = $clog2(MEM_WORDS + 1);

   state_t           state;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] last_word;
   logic [7:0]       csum;

   logic             asm_valid;
   logic [31:0]      asm_word;
   logic             asm_done;

   // The assembler serves both the header and the payload; restart discards the byte.
   assign asm_valid = rx_valid && !restart && ((state == StHeader) || (state == StPayload));

   word_assembler u_word_assembler (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (restart),
      .byte_valid (asm_valid),
      .byte_data  (rx_data),
      .word       (asm_word),
      .word_done  (asm_done)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state             <= StHeader;
         word_cnt          <= '0;
         last_word         <= '0;
         csum              <= 8'h0;
         mem_write_enable  <= 1'b0;
         mem_write_address <= '0;
         mem_write_data    <= 32'h0;
         load_done         <= 1'b0;
         load_error        <= 1'b0;
      end else begin
         mem_write_enable <= 1'b0;
         if (restart) begin
            state      <= StHeader;
            word_cnt   <= '0;
            last_word  <= '0;
            csum       <= 8'h0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
         end else if (rx_valid) begin
            case (state)
               StHeader: begin
                  if (asm_done) begin
                     if (asm_word > 32'(MEM_WORDS)) begin
                        state      <= StError;
                        load_error <= 1'b1;
                     end else if (asm_word == 32'h0) begin
                        state <= StChecksum;
                     end else begin
                        state     <= StPayload;
                        last_word <= CNT_W'(asm_word - 32'd1);
                     end
                  end
               end
               StPayload: begin
                  csum <= csum ^ rx_data;
                  if (asm_done) begin
                     mem_write_enable  <= 1'b1;
                     mem_write_address <= ADDR_W'({word_cnt, 2'b00});
                     mem_write_data    <= asm_word;
                     if (word_cnt == last_word) begin
                        state <= StChecksum;
                     end else begin
                        word_cnt <= word_cnt + 1'b1;
                     end
                  end
               end
               StChecksum: begin
                  if (rx_data == csum) begin
                     state     <= StDone;
                     load_done <= 1'b1;
                  end else begin
                     state      <= StError;
                     load_error <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
